// File: rtl/lock_chamber_sequencer.sv
// rtl/lock_chamber_sequencer.sv - two-port pressure chamber trip sequencer
// Moore outputs decoded from registered state; requests are accepted only in IDLE.
module lock_chamber_sequencer #(
  parameter int PRESS_CYCLES = 8,
  parameter int DOOR_CYCLES  = 4,
  parameter int CNT_W        = 8
) (
  input  logic timer,
  input  logic rst,
  input  logic arriveSignal,
  input  logic leaveSignal,
  output logic outerPort,
  output logic innerPort,
  output logic pressurizing,
  output logic depressurizing,
  output logic chamberHigh,
  output logic busy,
  output logic done
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PRESS      = 3'd1,
    DEPRESS    = 3'd2,
    OPEN_OUTER = 3'd3,
    OPEN_INNER = 3'd4
  } state_t;

  typedef enum logic {
    TRIP_ARRIVE = 1'b0,
    TRIP_LEAVE  = 1'b1
  } trip_t;

  localparam logic [CNT_W-1:0] PRESS_LOAD = CNT_W'(PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOOR_LOAD  = CNT_W'(DOOR_CYCLES - 1);

  state_t           r_state;
  trip_t            r_trip;
  logic             r_leg;
  logic [CNT_W-1:0] r_count;
  logic             r_chamber_high;
  logic             r_done;

  state_t           w_next_state;
  trip_t            w_next_trip;
  logic             w_next_leg;
  logic [CNT_W-1:0] w_next_count;
  logic             w_next_high;
  logic             w_next_done;
  logic             w_enter;
  logic             w_phase_end;

  assign w_phase_end = (r_count == '0);

  always_ff @(posedge timer or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_trip         <= TRIP_ARRIVE;
      r_leg          <= 1'b0;
      r_count        <= '0;
      r_chamber_high <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_trip         <= w_next_trip;
      r_leg          <= w_next_leg;
      r_count        <= w_next_count;
      r_chamber_high <= w_next_high;
      r_done         <= w_next_done;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_trip  = r_trip;
    w_next_leg   = r_leg;
    w_next_high  = r_chamber_high;
    w_next_done  = 1'b0;
    w_enter      = 1'b0;
    w_next_count = w_phase_end ? r_count : r_count - 1'b1;

    case (r_state)
      IDLE: begin
        if (arriveSignal) begin
          w_next_trip  = TRIP_ARRIVE;
          w_next_leg   = 1'b0;
          w_next_state = r_chamber_high ? DEPRESS : OPEN_OUTER;
          w_enter      = 1'b1;
        end else if (leaveSignal) begin
          w_next_trip  = TRIP_LEAVE;
          w_next_leg   = 1'b0;
          w_next_state = r_chamber_high ? OPEN_INNER : PRESS;
          w_enter      = 1'b1;
        end
      end
      PRESS, DEPRESS: begin
        if (w_phase_end) begin
          w_next_high  = (r_state == PRESS);
          // The outer side is next when trip direction and leg agree (LEAVE/1 or ARRIVE/0).
          w_next_state = ((r_trip == TRIP_LEAVE) == r_leg) ? OPEN_OUTER : OPEN_INNER;
          w_enter      = 1'b1;
        end
      end
      OPEN_OUTER, OPEN_INNER: begin
        if (w_phase_end) begin
          if (!r_leg) begin
            w_next_leg   = 1'b1;
            w_next_state = (r_trip == TRIP_ARRIVE) ? PRESS : DEPRESS;
            w_enter      = 1'b1;
          end else begin
            w_next_state = IDLE;
            w_next_done  = 1'b1;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase

    if (w_enter) begin
      w_next_count = ((w_next_state == PRESS) || (w_next_state == DEPRESS)) ? PRESS_LOAD : DOOR_LOAD;
    end
  end

  assign pressurizing   = (r_state == PRESS);
  assign depressurizing = (r_state == DEPRESS);
  assign outerPort      = (r_state == OPEN_OUTER);
  assign innerPort      = (r_state == OPEN_INNER);
  assign busy           = (r_state != IDLE);
  assign chamberHigh    = r_chamber_high;
  assign done           = r_done;

endmodule

// File: tb/tb_lock_chamber_sequencer.sv
// tb/tb_lock_chamber_sequencer.sv - self-checking bench for lock_chamber_sequencer
// A trip-plan queue model predicts every output cycle; a second fast instance runs a random stream.
module tb_lock_chamber_sequencer;

  localparam int P  = 8;
  localparam int D  = 4;
  localparam int PF = 1;
  localparam int DF = 1;

  logic timer = 1'b0;
  logic rst;
  logic arriveSignal, leaveSignal;
  logic outerPort, innerPort, pressurizing, depressurizing, chamberHigh, busy, done;
  logic f_arrive, f_leave;
  logic f_outer, f_inner, f_press, f_depress, f_high, f_busy, f_done;

  int n_vec = 0;
  int n_err = 0;

  always #5 timer = ~timer;

  lock_chamber_sequencer #(.PRESS_CYCLES(P), .DOOR_CYCLES(D), .CNT_W(8)) dut (
    .timer(timer), .rst(rst), .arriveSignal(arriveSignal), .leaveSignal(leaveSignal),
    .outerPort(outerPort), .innerPort(innerPort), .pressurizing(pressurizing),
    .depressurizing(depressurizing), .chamberHigh(chamberHigh), .busy(busy), .done(done)
  );

  lock_chamber_sequencer #(.PRESS_CYCLES(PF), .DOOR_CYCLES(DF), .CNT_W(8)) dut_fast (
    .timer(timer), .rst(rst), .arriveSignal(f_arrive), .leaveSignal(f_leave),
    .outerPort(f_outer), .innerPort(f_inner), .pressurizing(f_press),
    .depressurizing(f_depress), .chamberHigh(f_high), .busy(f_busy), .done(f_done)
  );

  wire [6:0] w_vec = {outerPort, innerPort, pressurizing, depressurizing, chamberHigh, busy, done};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Model: vector bits are {outer, inner, press, depress, high, busy, done}.
  logic [6:0] q[$];
  logic [6:0] m_cur;

  function automatic logic [6:0] mk(bit o, bit i, bit p, bit d, bit h, bit b, bit dn);
    return {o, i, p, d, h, b, dn};
  endfunction

  task automatic push_seg(input logic [6:0] v, input int n);
    for (int j = 0; j < n; j++) q.push_back(v);
  endtask

  task automatic plan_trip(input bit arr);
    bit h;
    h = m_cur[2];
    if (arr) begin
      if (h) push_seg(mk(0, 0, 0, 1, 1, 1, 0), P);
      push_seg(mk(1, 0, 0, 0, 0, 1, 0), D);
      push_seg(mk(0, 0, 1, 0, 0, 1, 0), P);
      push_seg(mk(0, 1, 0, 0, 1, 1, 0), D);
      q.push_back(mk(0, 0, 0, 0, 1, 0, 1));
    end else begin
      if (!h) push_seg(mk(0, 0, 1, 0, 0, 1, 0), P);
      push_seg(mk(0, 1, 0, 0, 1, 1, 0), D);
      push_seg(mk(0, 0, 0, 1, 1, 1, 0), P);
      push_seg(mk(1, 0, 0, 0, 0, 1, 0), D);
      q.push_back(mk(0, 0, 0, 0, 0, 0, 1));
    end
  endtask

  always @(posedge timer or posedge rst) begin
    if (rst) begin
      q.delete();
      m_cur = '0;
    end else begin
      if (!m_cur[1] && (arriveSignal || leaveSignal)) plan_trip(arriveSignal);
      if (q.size() > 0) m_cur = q.pop_front();
      else m_cur = mk(0, 0, 0, 0, m_cur[2], 0, 0);
    end
  end

  always @(negedge timer) begin
    if (!rst) chk("model_vec", {25'd0, w_vec}, {25'd0, m_cur});
  end

  // Fast-instance model: only busy length, done timing and accepted trip count.
  int  m2_rem = 0;
  bit  m2_high = 0;
  bit  m2_done = 0;
  int  m2_acc = 0;
  int  f_done_cnt = 0;

  always @(posedge timer or posedge rst) begin
    if (rst) begin
      m2_rem = 0; m2_high = 0; m2_done = 0;
    end else if (m2_rem == 0 && (f_arrive || f_leave)) begin
      if (f_arrive) m2_rem = (m2_high ? PF : 0) + DF + PF + DF;
      else          m2_rem = (!m2_high ? PF : 0) + DF + PF + DF;
      m2_high = f_arrive;
      m2_done = 0;
      m2_acc++;
    end else if (m2_rem > 0) begin
      m2_rem--;
      m2_done = (m2_rem == 0);
    end else begin
      m2_done = 0;
    end
  end

  always @(negedge timer) begin
    if (!rst) begin
      chk("fast_busy_done", {30'd0, f_busy, f_done}, {30'd0, (m2_rem > 0), m2_done});
      chk("fast_invariants",
          {28'd0, (f_outer & f_high), (f_inner & ~f_high), (f_outer & f_inner), (f_press & f_depress)}, 32'd0);
      if (f_done) f_done_cnt++;
    end
  end

  task automatic do_reset();
    @(negedge timer) rst = 1'b1;
    @(negedge timer) rst = 1'b0;
  endtask

  initial begin
    int done_cnt, outer_cnt;
    rst = 1'b1; arriveSignal = 0; leaveSignal = 0; f_arrive = 0; f_leave = 0;
    repeat (2) @(negedge timer);
    chk("reset_state", {25'd0, w_vec}, 32'd0);
    rst = 1'b0;

    @(negedge timer) arriveSignal = 1;
    for (int k = 1; k <= 17; k++) begin
      @(negedge timer);
      if (k == 1) arriveSignal = 0;
      chk("arr_outer", outerPort, (k >= 1 && k <= 4));
      chk("arr_press", pressurizing, (k >= 5 && k <= 12));
      chk("arr_inner", innerPort, (k >= 13 && k <= 16));
      chk("arr_high", chamberHigh, (k >= 13));
      chk("arr_done_busy", {busy, done}, {(k < 17), (k == 17)});
    end

    do_reset();
    @(negedge timer) leaveSignal = 1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge timer);
      if (k == 1) leaveSignal = 0;
      chk("lv_press", pressurizing, (k <= 8));
      chk("lv_inner", innerPort, (k >= 9 && k <= 12));
      chk("lv_depress", depressurizing, (k >= 13 && k <= 20));
      chk("lv_outer", outerPort, (k >= 21 && k <= 24));
      chk("lv_high", chamberHigh, (k >= 9 && k <= 20));
      chk("lv_done", done, (k == 25));
    end

    do_reset();
    @(negedge timer) begin arriveSignal = 1; leaveSignal = 1; end
    @(negedge timer) arriveSignal = 0;
    chk("both_outer_first", {outerPort, pressurizing}, 2'b10);
    repeat (16) @(negedge timer);
    chk("both_done17", done, 1);
    @(negedge timer);
    chk("both_leave_next", {innerPort, busy}, 2'b11);
    leaveSignal = 0;
    repeat (20) @(negedge timer);

    @(negedge timer) arriveSignal = 1;
    done_cnt = 0; outer_cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge timer);
      if (done) done_cnt++;
      if (outerPort) outer_cnt++;
      arriveSignal = (k >= 2 && k <= 14 && (k % 2 == 0));
    end
    chk("ignored_done_cnt", done_cnt, 1);
    chk("ignored_outer_cnt", outer_cnt, D);

    do_reset();
    @(negedge timer) arriveSignal = 1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge timer);
      if (k == 1) arriveSignal = 0;
    end
    chk("mid_press", pressurizing, 1);
    #2 rst = 1'b1;
    #1 chk("mid_reset_outputs", {25'd0, w_vec}, 32'd0);
    @(negedge timer) rst = 1'b0;
    @(negedge timer) arriveSignal = 1;
    @(negedge timer) arriveSignal = 0;
    chk("restart_outer", {outerPort, chamberHigh}, 2'b10);
    repeat (20) @(negedge timer);

    for (int i = 0; i < 10000; i++) begin
      @(negedge timer);
      f_arrive = ($urandom_range(0, 3) == 0);
      f_leave  = ($urandom_range(0, 3) == 0);
    end
    @(negedge timer) begin f_arrive = 0; f_leave = 0; end
    repeat (10) @(negedge timer);
    chk("fast_done_vs_trips", f_done_cnt, m2_acc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lock_chamber_sequencer.md
Name: lock_chamber_sequencer

Overview:
- Sequences the two-port pressure chamber for one vessel trip.
- Consumes the arrival and departure request levels built from the switch and pressure-sensor logic.
- Drives the outer port, inner port, and pressurize/depressurize actuators.
- Enforces the safety invariants: a port opens only when chamber pressure matches its side, the two ports are never open together, and the pump runs in one direction at a time.

Parameters:
- PRESS_CYCLES, 8: cycles one pressurize or depressurize phase lasts (≥1).
- DOOR_CYCLES, 4: cycles a port is held open for vessel transit (≥1).
- CNT_W, 8: phase counter width; must hold max(PRESS_CYCLES, DOOR_CYCLES)-1.

Ports:
- timer  input  1  clock for all state; rising edge.
- rst  input  1  reset, asynchronous, active-high.
- arriveSignal  input  1  arrival request level (vessel outside wants in).
- leaveSignal  input  1  departure request level (vessel inside wants out).
- outerPort  output  1  outer port open command.
- innerPort  output  1  inner port open command.
- pressurizing  output  1  pump raising chamber to inside pressure.
- depressurizing  output  1  pump lowering chamber to outside pressure.
- chamberHigh  output  1  1 = chamber at inside pressure, 0 = at outside pressure.
- busy  output  1  trip in progress (state != IDLE).
- done  output  1  one-cycle pulse on trip completion.

Behaviour:
- Clock and reset: one clock, timer. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, trip=ARRIVE, leg=0, count=0, chamberHigh=0. All other outputs 0.
- Reset mid-trip: aborts immediately to the reset values; no completion pulse.
- States: IDLE, PRESS, DEPRESS, OPEN_OUTER, OPEN_INNER.
- Outputs are Moore decodes of registered state, asserted for every cycle the state is held:
  - pressurizing = PRESS
  - depressurizing = DEPRESS
  - outerPort = OPEN_OUTER
  - innerPort = OPEN_INNER
- busy = (state != IDLE).
- IDLE request handling:
  - Requests are sampled only in IDLE. Requests while busy are ignored, not queued.
  - arriveSignal has priority when both are high.
  - arriveSignal: trip<=ARRIVE, leg<=0; next state is DEPRESS if chamberHigh, else OPEN_OUTER.
  - leaveSignal: trip<=LEAVE, leg<=0; next state is PRESS if !chamberHigh, else OPEN_INNER.
  - A request seen at edge t puts the block in the new state from cycle t+1.
- Phase timing:
  - On entry to any non-IDLE state, count loads N-1 (N = PRESS_CYCLES or DOOR_CYCLES).
  - count decrements each cycle; the state exits on the edge where count==0. Each state therefore lasts exactly N cycles.
- PRESS exit: chamberHigh<=1. DEPRESS exit: chamberHigh<=0. Both take effect in the first cycle of the following state.
- Pressure-state exit destination:
  - ARRIVE: OPEN_OUTER if leg=0, OPEN_INNER if leg=1.
  - LEAVE: OPEN_INNER if leg=0, OPEN_OUTER if leg=1.
- Door-state exit:
  - leg=0: leg<=1, go to PRESS (ARRIVE) or DEPRESS (LEAVE).
  - leg=1: go to IDLE, done=1 for exactly the first IDLE cycle.
  - The done cycle also samples requests, so back-to-back trips are allowed.
- Trip sequences:
  - ARRIVE: [DEPRESS] → OPEN_OUTER → PRESS → OPEN_INNER → IDLE.
  - LEAVE: [PRESS] → OPEN_INNER → DEPRESS → OPEN_OUTER → IDLE.
- Invariants, checked every cycle:
  - outerPort implies !chamberHigh.
  - innerPort implies chamberHigh.
  - Never outerPort and innerPort together.
  - Never pressurizing and depressurizing together.
- Arithmetic: count is unsigned CNT_W and never wraps. It is only decremented when nonzero.

Test Plan:
- Arrive from reset (defaults), arriveSignal high 1 cycle at cycle 0:
  - outerPort=1 cycles 1–4; pressurizing=1 cycles 5–12.
  - chamberHigh=1 from cycle 13; innerPort=1 cycles 13–16.
  - done=1 and busy=0 at cycle 17.
- Leave with chamberHigh=0 (from reset), leaveSignal pulse at cycle 0:
  - pressurizing cycles 1–8; innerPort 9–12; depressurizing 13–20; outerPort 21–24.
  - done at 25; chamberHigh ends 0.
- Arrive and leave high together in IDLE → ARRIVE trip taken (outerPort first). leaveSignal held high throughout → LEAVE trip begins cycle after done.
- arriveSignal pulsed repeatedly during a trip → ignored; exactly one done pulse; no extra door cycles.
- rst asserted mid-PRESS (cycle 7 of the arrive trip) → all outputs 0 immediately, chamberHigh=0, no done; next arrival restarts at OPEN_OUTER.
- Random request stream, 10k cycles, PRESS_CYCLES=1, DOOR_CYCLES=1 → invariant assertions never fire; count of done pulses equals accepted trips.
